// File: rtl/reg_res_scheduler.sv
// Register-reservation scheduler: hazard check, destination reservation and
// single-result-bus slot booking, replayed as write-back controls from slot 0.
module reg_res_scheduler #(
    parameter int NREGS   = 8,
    parameter int IDX_W   = $clog2(NREGS),
    parameter int MAX_LAT = 14,
    parameter int SRC_W   = 4,
    parameter int CNT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_advance,
    input  logic             i_flush,
    input  logic             i_req,
    input  logic             i_dest_en,
    input  logic [IDX_W-1:0] i_dest,
    input  logic [NREGS-1:0] i_rd_mask,
    input  logic [4:0]       i_lat,
    input  logic [SRC_W-1:0] i_src,
    output logic             o_issue_ok,
    output logic             o_rej_hazard,
    output logic             o_rej_bus,
    output logic             o_rej_lat,
    output logic             o_result_en,
    output logic [IDX_W-1:0] o_result_dest,
    output logic [SRC_W-1:0] o_result_src,
    output logic [NREGS-1:0] o_res_mask,
    output logic [CNT_W-1:0] o_busy_cnt
);

    localparam logic [5:0] MAX_LAT_V = 6'(MAX_LAT);

    logic [MAX_LAT-1:0] r_vld;
    logic [IDX_W-1:0]   r_dest [MAX_LAT];
    logic [SRC_W-1:0]   r_src  [MAX_LAT];

    logic [NREGS-1:0] w_res_mask;
    logic [CNT_W-1:0] w_busy_cnt;
    logic             w_lat_ok;
    logic             w_slot_hit;
    logic             w_hz;
    logic             w_bc;
    logic             w_commit;

    always_comb begin
        w_res_mask = '0;
        w_busy_cnt = '0;
        for (int s = 0; s < MAX_LAT; s++) begin
            if (r_vld[s]) begin
                w_res_mask[r_dest[s]] = 1'b1;
                w_busy_cnt            = w_busy_cnt + CNT_W'(1);
            end
        end
    end

    // slot[i_lat] is the one that shifts into the booked position slot[i_lat-1];
    // latency MAX_LAT books the top slot, which is always empty after the shift.
    always_comb begin
        w_slot_hit = 1'b0;
        for (int s = 1; s < MAX_LAT; s++) begin
            if (i_lat == 5'(s)) w_slot_hit = r_vld[s];
        end
    end

    assign w_lat_ok = (i_lat != 5'd0) && ({1'b0, i_lat} <= MAX_LAT_V);
    assign w_hz     = (|(i_rd_mask & w_res_mask)) | (i_dest_en & w_res_mask[i_dest]);
    assign w_bc     = i_dest_en & w_lat_ok & w_slot_hit;

    // Handshake: i_req is the candidate's valid, o_issue_ok its ready; the
    // transfer (commit) happens on an edge where both are high, i_advance=1
    // and i_flush=0. o_issue_ok may be sampled regardless of i_advance.
    assign o_issue_ok   = i_req & ~w_hz & ~w_bc & (~i_dest_en | w_lat_ok);
    assign o_rej_hazard = i_req & w_hz;
    assign o_rej_bus    = i_req & w_bc;
    assign o_rej_lat    = i_req & i_dest_en & ~w_lat_ok;
    assign w_commit     = o_issue_ok & i_advance & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_vld <= '0;
            for (int s = 0; s < MAX_LAT; s++) begin
                r_dest[s] <= '0;
                r_src[s]  <= '0;
            end
        end else if (i_advance) begin
            for (int s = 0; s < MAX_LAT - 1; s++) begin
                r_vld[s]  <= r_vld[s+1];
                r_dest[s] <= r_dest[s+1];
                r_src[s]  <= r_src[s+1];
            end
            r_vld[MAX_LAT-1]  <= 1'b0;
            r_dest[MAX_LAT-1] <= '0;
            r_src[MAX_LAT-1]  <= '0;
            if (w_commit && i_dest_en) begin
                for (int s = 0; s < MAX_LAT; s++) begin
                    if (i_lat == 5'(s + 1)) begin
                        r_vld[s]  <= 1'b1;
                        r_dest[s] <= i_dest;
                        r_src[s]  <= i_src;
                    end
                end
            end
        end
    end

    assign o_result_en   = r_vld[0];
    assign o_result_dest = r_dest[0];
    assign o_result_src  = r_src[0];
    assign o_res_mask    = w_res_mask;
    assign o_busy_cnt    = w_busy_cnt;

endmodule

// File: tb/tb_reg_res_scheduler.sv
// Directed bench for reg_res_scheduler: inputs change and outputs are sampled
// around the falling edge, state advances on the rising edge.
module tb_reg_res_scheduler;
    localparam int NREGS   = 8;
    localparam int IDX_W   = 3;
    localparam int MAX_LAT = 14;
    localparam int SRC_W   = 4;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             rst;
    logic             i_advance, i_flush, i_req, i_dest_en;
    logic [IDX_W-1:0] i_dest;
    logic [NREGS-1:0] i_rd_mask;
    logic [4:0]       i_lat;
    logic [SRC_W-1:0] i_src;
    logic             o_issue_ok, o_rej_hazard, o_rej_bus, o_rej_lat, o_result_en;
    logic [IDX_W-1:0] o_result_dest;
    logic [SRC_W-1:0] o_result_src;
    logic [NREGS-1:0] o_res_mask;
    logic [CNT_W-1:0] o_busy_cnt;

    int errors = 0;
    int checks = 0;

    reg_res_scheduler #(.NREGS(NREGS), .MAX_LAT(MAX_LAT), .SRC_W(SRC_W)) dut (
        .clk(clk), .rst(rst), .i_advance(i_advance), .i_flush(i_flush),
        .i_req(i_req), .i_dest_en(i_dest_en), .i_dest(i_dest), .i_rd_mask(i_rd_mask),
        .i_lat(i_lat), .i_src(i_src), .o_issue_ok(o_issue_ok), .o_rej_hazard(o_rej_hazard),
        .o_rej_bus(o_rej_bus), .o_rej_lat(o_rej_lat), .o_result_en(o_result_en),
        .o_result_dest(o_result_dest), .o_result_src(o_result_src),
        .o_res_mask(o_res_mask), .o_busy_cnt(o_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic req, input logic den, input logic [IDX_W-1:0] dest,
                         input logic [NREGS-1:0] rdm, input logic [4:0] lat,
                         input logic [SRC_W-1:0] src, input logic adv, input logic fl);
        i_req = req; i_dest_en = den; i_dest = dest; i_rd_mask = rdm;
        i_lat = lat; i_src = src; i_advance = adv; i_flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 5'd0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 3'd6, 8'h00, 5'd1, 4'd3, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        checks++; if (o_result_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%0b exp=0", o_result_en); end
        checks++; if (o_result_dest !== 3'd0) begin errors++; $display("FAIL reset_dest got=%0d exp=0", o_result_dest); end
        checks++; if (o_result_src !== 4'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", o_result_src); end
        checks++; if (o_res_mask !== 8'h00) begin errors++; $display("FAIL reset_mask got=%0h exp=0", o_res_mask); end
        checks++; if (o_busy_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", o_busy_cnt); end
        checks++; if (o_issue_ok !== 1'b0) begin errors++; $display("FAIL noreq_ok got=%0b exp=0", o_issue_ok); end
    endtask

    task automatic test_lat1();
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd3, 8'h00, 5'd1, 4'd5, 1'b1, 1'b0);
        #1;
        checks++; if (o_issue_ok !== 1'b1) begin errors++; $display("FAIL lat1_ok got=%0b exp=1", o_issue_ok); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (o_result_en !== 1'b1) begin errors++; $display("FAIL lat1_en got=%0b exp=1", o_result_en); end
        checks++; if (o_result_dest !== 3'd3) begin errors++; $display("FAIL lat1_dest got=%0d exp=3", o_result_dest); end
        checks++; if (o_result_src !== 4'd5) begin errors++; $display("FAIL lat1_src got=%0d exp=5", o_result_src); end
        checks++; if (o_res_mask !== 8'h08) begin errors++; $display("FAIL lat1_mask got=%0h exp=08", o_res_mask); end
        checks++; if (o_busy_cnt !== 4'd1) begin errors++; $display("FAIL lat1_cnt got=%0d exp=1", o_busy_cnt); end
        @(negedge clk);
        #1;
        checks++; if (o_result_en !== 1'b0) begin errors++; $display("FAIL lat1_after_en got=%0b exp=0", o_result_en); end
        checks++; if (o_result_dest !== 3'd0) begin errors++; $display("FAIL lat1_after_dest got=%0d exp=0", o_result_dest); end
        checks++; if (o_res_mask !== 8'h00) begin errors++; $display("FAIL lat1_after_mask got=%0h exp=0", o_res_mask); end
        checks++; if (o_busy_cnt !== 4'd0) begin errors++; $display("FAIL lat1_after_cnt got=%0d exp=0", o_busy_cnt); end
    endtask

    task automatic test_hazard();
        logic exp_blk;
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd2, 8'h00, 5'd6, 4'd1, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 3) drive(1'b1, 1'b1, 3'd2, 8'h00, 5'd2, 4'd1, 1'b1, 1'b0);
            else        drive(1'b1, 1'b0, 3'd0, 8'h04, 5'd0, 4'd0, 1'b1, 1'b0);
            #1;
            exp_blk = (k <= 6);
            checks++; if (o_rej_hazard !== exp_blk) begin errors++; $display("FAIL hazard_rej k=%0d got=%0b exp=%0b", k, o_rej_hazard, exp_blk); end
            checks++; if (o_issue_ok !== !exp_blk) begin errors++; $display("FAIL hazard_ok k=%0d got=%0b exp=%0b", k, o_issue_ok, !exp_blk); end
            checks++; if (o_result_en !== (k == 6)) begin errors++; $display("FAIL hazard_wb k=%0d got=%0b exp=%0b", k, o_result_en, (k == 6)); end
        end
        idle();
    endtask

    task automatic test_bus();
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd1, 8'h00, 5'd4, 4'd1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd5, 8'h00, 5'd3, 4'd2, 1'b1, 1'b0);
        #1;
        checks++; if (o_rej_bus !== 1'b1) begin errors++; $display("FAIL bus_rej got=%0b exp=1", o_rej_bus); end
        checks++; if (o_issue_ok !== 1'b0) begin errors++; $display("FAIL bus_ok3 got=%0b exp=0", o_issue_ok); end
        i_lat = 5'd2;
        #1;
        checks++; if (o_issue_ok !== 1'b1) begin errors++; $display("FAIL bus_ok2 got=%0b exp=1", o_issue_ok); end
        checks++; if (o_rej_bus !== 1'b0) begin errors++; $display("FAIL bus_rej2 got=%0b exp=0", o_rej_bus); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (o_res_mask !== 8'h22) begin errors++; $display("FAIL bus_mask got=%0h exp=22", o_res_mask); end
        checks++; if (o_busy_cnt !== 4'd2) begin errors++; $display("FAIL bus_cnt got=%0d exp=2", o_busy_cnt); end
        @(negedge clk);
        #1;
        checks++; if (o_result_en !== 1'b1 || o_result_dest !== 3'd5) begin errors++; $display("FAIL bus_first got=%0b/%0d exp=1/5", o_result_en, o_result_dest); end
        @(negedge clk);
        #1;
        checks++; if (o_result_en !== 1'b1 || o_result_dest !== 3'd1) begin errors++; $display("FAIL bus_second got=%0b/%0d exp=1/1", o_result_en, o_result_dest); end
        @(negedge clk);
        #1;
        checks++; if (o_result_en !== 1'b0) begin errors++; $display("FAIL bus_done got=%0b exp=0", o_result_en); end
    endtask

    task automatic test_lat_limits();
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd7, 8'h00, 5'd0, 4'd9, 1'b1, 1'b0);
        #1;
        checks++; if (o_rej_lat !== 1'b1 || o_issue_ok !== 1'b0) begin errors++; $display("FAIL lat0 got=rej%0b/ok%0b exp=1/0", o_rej_lat, o_issue_ok); end
        @(negedge clk);
        i_lat = 5'd15;
        #1;
        checks++; if (o_rej_lat !== 1'b1 || o_issue_ok !== 1'b0) begin errors++; $display("FAIL lat15 got=rej%0b/ok%0b exp=1/0", o_rej_lat, o_issue_ok); end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd7, 8'h00, 5'd0, 4'd9, 1'b1, 1'b0);
        #1;
        checks++; if (o_busy_cnt !== 4'd0) begin errors++; $display("FAIL latbad_nocommit got=%0d exp=0", o_busy_cnt); end
        checks++; if (o_rej_lat !== 1'b0 || o_issue_ok !== 1'b1) begin errors++; $display("FAIL nodest got=rej%0b/ok%0b exp=0/1", o_rej_lat, o_issue_ok); end
        @(negedge clk);
        checks++; if (o_busy_cnt !== 4'd0) begin errors++; $display("FAIL nodest_nocommit got=%0d exp=0", o_busy_cnt); end
        drive(1'b1, 1'b1, 3'd7, 8'h00, 5'd14, 4'd9, 1'b1, 1'b0);
        #1;
        checks++; if (o_issue_ok !== 1'b1) begin errors++; $display("FAIL lat14_ok got=%0b exp=1", o_issue_ok); end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            idle();
            #1;
            checks++; if (o_result_en !== (k == 14)) begin errors++; $display("FAIL lat14_en k=%0d got=%0b exp=%0b", k, o_result_en, (k == 14)); end
            if (k == 14) begin
                checks++; if (o_result_dest !== 3'd7 || o_result_src !== 4'd9) begin errors++; $display("FAIL lat14_wb got=%0d/%0d exp=7/9", o_result_dest, o_result_src); end
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd4, 8'h00, 5'd3, 4'd2, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 2) drive(1'b1, 1'b1, 3'd6, 8'h00, 5'd1, 4'd3, 1'b0, 1'b0);
            else        idle();
            #1;
            if (k <= 2) begin
                checks++; if (o_issue_ok !== 1'b1) begin errors++; $display("FAIL stall_ok k=%0d got=%0b exp=1", k, o_issue_ok); end
            end
            checks++; if (o_result_en !== (k == 5)) begin errors++; $display("FAIL stall_en k=%0d got=%0b exp=%0b", k, o_result_en, (k == 5)); end
            checks++; if (o_res_mask !== ((k <= 5) ? 8'h10 : 8'h00)) begin errors++; $display("FAIL stall_mask k=%0d got=%0h exp=%0h", k, o_res_mask, ((k <= 5) ? 8'h10 : 8'h00)); end
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd1, 8'h00, 5'd5, 4'd1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd2, 8'h00, 5'd6, 4'd2, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd3, 8'h00, 5'd7, 4'd3, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd4, 8'h00, 5'd1, 4'd4, 1'b1, 1'b1);
        #1;
        checks++; if (o_busy_cnt !== 4'd3 || o_res_mask !== 8'h0e) begin errors++; $display("FAIL preflush got=%0d/%0h exp=3/0e", o_busy_cnt, o_res_mask); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (o_busy_cnt !== 4'd0 || o_res_mask !== 8'h00) begin errors++; $display("FAIL flush got=%0d/%0h exp=0/0", o_busy_cnt, o_res_mask); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (o_result_en !== 1'b0) begin errors++; $display("FAIL flush_en k=%0d got=%0b exp=0", k, o_result_en); end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd5, 8'h00, 5'd2, 4'd7, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1, 3'd6, 8'h00, 5'd1, 4'd7, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        checks++; if (o_busy_cnt !== 4'd0 || o_res_mask !== 8'h00 || o_result_en !== 1'b0) begin errors++; $display("FAIL rstmid got=%0d/%0h/%0b exp=0/0/0", o_busy_cnt, o_res_mask, o_result_en); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_lat1();
        test_hazard();
        test_bus();
        test_lat_limits();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_res_scheduler.md
# reg_res_scheduler

Parametrised register-reservation scheduler for issue control of one register file (A, S or B class). For every candidate instruction it checks read/write hazards against results still in flight, reserves the destination register, and books a single-result-bus slot at the instruction's latency. The booked result is later replayed as write-back controls (enable, source unit, destination index). It sits between instruction decode and the register-file write port and generalises the fixed 8-register, fixed-latency-set A-register scheduler. It adds runtime latency, result-bus collision detection, explicit reject reasons, flush, and occupancy count.

## Interface
Parameters:
- NREGS, 8, registers tracked (power of two, 2..64)
- IDX_W, $clog2(NREGS), register index width
- MAX_LAT, 14, largest legal result latency in cycles (2..31)
- SRC_W, 4, functional-unit source code width
- CNT_W, $clog2(MAX_LAT+1), occupancy counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_advance  in  1  pipeline advance; slots shift and issue commits only when 1
- i_flush  in  1  discard all in-flight reservations
- i_req  in  1  candidate instruction present
- i_dest_en  in  1  candidate writes a register of this file
- i_dest  in  IDX_W  destination index
- i_rd_mask  in  NREGS  one-hot-or registers read by candidate
- i_lat  in  5  result latency of candidate
- i_src  in  SRC_W  functional-unit code of candidate
- o_issue_ok  out  1  candidate may issue this cycle (combinational)
- o_rej_hazard  out  1  blocked by register reservation
- o_rej_bus  out  1  blocked by result-bus slot already booked
- o_rej_lat  out  1  i_lat illegal (0 or > MAX_LAT) with i_dest_en
- o_result_en  out  1  write-back valid
- o_result_dest  out  IDX_W  write-back register index
- o_result_src  out  SRC_W  write-back source unit
- o_res_mask  out  NREGS  registers with a pending result
- o_busy_cnt  out  CNT_W  number of valid slots

## Operation
- Storage: MAX_LAT slots, slot s = {vld, dest[IDX_W], src[SRC_W]}. Slot 0 drives o_result_*: o_result_en = slot0.vld; dest/src pass through unmasked.
- o_res_mask = OR over valid slots of one-hot(dest). o_busy_cnt = popcount of vld bits.
- Hazard: hz = |(i_rd_mask & o_res_mask) | (i_dest_en & o_res_mask[i_dest]). Both RAW and WAW are covered.
- Legal latency: lat_ok = (i_lat >= 1) && (i_lat <= MAX_LAT).
- Bus conflict: bc = i_dest_en && lat_ok && (i_lat < MAX_LAT) && slot[i_lat].vld. A latency of MAX_LAT never conflicts.
- o_rej_lat = i_req & i_dest_en & !lat_ok.
- o_rej_hazard = i_req & hz.
- o_rej_bus = i_req & bc.
- Several reject flags may be asserted together.
- o_issue_ok = i_req & !hz & !bc & (!i_dest_en | lat_ok). Without i_dest_en, i_lat and i_src are ignored.
- Commit = o_issue_ok & i_advance & !i_flush.
- Clocked update, in priority order:
  - rst: all slots cleared.
  - else i_flush: all slots cleared, regardless of i_advance.
  - else i_advance: slot[s] <= slot[s+1] for s < MAX_LAT-1, and slot[MAX_LAT-1] <= 0.
    - If commit & i_dest_en, slot[i_lat-1] is overwritten with {1, i_dest, i_src}.
    - Absence of bc guarantees this slot would otherwise be empty.
  - else: hold.
- Commit without i_dest_en changes no slot.
- When i_advance=0, o_issue_ok still evaluates but nothing commits. Outputs are stable.

## Timing
- Reset: all slots zero. After reset, o_result_en=0, o_result_dest=0, o_result_src=0, o_res_mask=0, o_busy_cnt=0. Reject flags follow inputs combinationally.
- Latency L committed at edge T with i_advance=1 every cycle: o_result_en high for exactly one cycle, after the edge T+L-1. That is the L-th cycle after issue, with L=1 meaning the cycle after the issue edge.
- Each stalled cycle (i_advance=0) extends the delay by one.
- o_res_mask[d] asserts the cycle after commit and deasserts the cycle after o_result_en for d drops.
- The register is blocked while its write-back is on the bus, and is readable the following cycle.
- Flush: one cycle after the flush edge, all outputs except the reject flags are zero. A same-cycle commit is discarded.
- Reset mid-operation: identical to flush.
- No combinational path from i_* to o_result_*, o_res_mask, or o_busy_cnt.

## Test plan
- Reset, then commit dest=3, lat=1, src=5 -> next cycle o_result_en=1, dest=3, src=5, o_res_mask=0x08, o_busy_cnt=1; the cycle after, all zero.
- Commit dest=2, lat=6, then present i_rd_mask=0x04 -> o_issue_ok=0, o_rej_hazard=1 until the cycle after write-back; also present i_dest=2 with i_rd_mask=0 -> WAW reject.
- Commit dest=1, lat=4; next cycle request dest=5, lat=3 -> o_rej_bus=1. The same request with lat=2 -> o_issue_ok=1, and the results appear on consecutive cycles in order 5 then 1.
- i_lat=0 and i_lat=MAX_LAT+1 with i_dest_en=1 -> o_rej_lat=1, no commit. i_lat=MAX_LAT -> accepted, result after MAX_LAT cycles.
- Commit lat=3, then i_advance=0 for 2 cycles -> result after 5 cycles; o_res_mask held throughout.
- Three reservations in flight, assert i_flush together with a legal request -> next cycle o_busy_cnt=0, o_res_mask=0, and no o_result_en afterwards.
